cla_serial_add_ctrl: RTL and testbench

//  Sequencer that adds/subtracts WIDTH-bit operands on one shared 4-bit carry-lookahead slice, one nibble per cycle, LSB first.

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla4_slice.sv | 28 ++
 rtl/cla_serial_add_ctrl.sv | 142 ++++++++++++++
 tb/tb_cla_serial_add_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead adder.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count n nibble cycles; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit generate/propagate carry-lookahead slice; zero latency, no flow control.
// c3 is the carry into bit 3, exposed for signed-overflow detection.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial add/sub on one shared CLA slice; result valid WIDTH/4 edges after accept, held until res_ready.
// No new operands accepted until the result handshake. SIGNED_OVF_EN enables the ovf output.
module cla_serial_add_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = clog2(NIBBLES);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 2 * NIBBLE_W)) begin : g_bad_width
    $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_c3;
  logic                slice_co;
  logic                last_nibble;
  logic                unused_sig;

  cla4_slice u_slice (
    .a  (a_q[NIBBLE_W-1:0]),
    .b  (b_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .c3 (slice_c3),
    .co (slice_co)
  );

  assign last_nibble = (cnt_q == CNT_W'(NIBBLES - 1));

  // The low nibble of acc is always shifted out before the result is formed.
`ifdef SIGNED_OVF_EN
  assign unused_sig = ^acc_q[NIBBLE_W-1:0];
`else
  assign unused_sig = ^{slice_c3, acc_q[NIBBLE_W-1:0]};
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          a_d     = op_a;
          b_d     = op_b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : c_in;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // Result nibbles enter from the MSB side so the LSB ends up at bit 0.
        acc_d   = {slice_s, acc_q[WIDTH-1:NIBBLE_W]};
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        carry_d = slice_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_nibble) begin
          sum_d   = acc_d;
          c_out_d = slice_co;
`ifdef SIGNED_OVF_EN
          ovf_d   = slice_c3 ^ slice_co;
`else
          ovf_d   = 1'b0;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed, table-driven bench for cla_serial_add_ctrl at WIDTH=16 (both SIGNED_OVF_EN builds).
module tb_cla_serial_add_ctrl;

`ifdef SIGNED_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        c_in;
  logic        sub;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  int tests;
  int fails;

  cla_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .c_in        (c_in),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .c_out       (c_out),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sb;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation, check latency and result, then complete the handshake.
  task automatic run_op(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, " start_ready"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    op_a = v.a;
    op_b = v.b;
    c_in = v.cin;
    sub  = v.sb;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op_a = ~v.a;
    op_b = ~v.b;
    c_in = ~v.cin;
    sub  = ~v.sb;
    chk({nm, " busy"}, 32'(start_ready), 32'd0);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'd4);
    chk({nm, " sum"}, 32'(sum), 32'(v.s));
    chk({nm, " c_out"}, 32'(c_out), 32'(v.co));
    chk({nm, " ovf"}, 32'(ovf), 32'(v.ov & OVF_EN));
    @(posedge clk);
    #1;
    chk({nm, " idle"}, {30'd0, res_valid, start_ready}, 32'b01);
    chk({nm, " sum held"}, 32'(sum), 32'(v.s));
  endtask

  initial begin
    vec_t v;
    int   lat;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    c_in = 1'b0;
    sub  = 1'b0;
    res_ready = 1'b1;

    //         a         b         cin   sub   sum       co    ov
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[8] = '{16'h0010, 16'h0008, 1'b1, 1'b1, 16'h0008, 1'b1, 1'b0};

    #12;
    chk("reset outputs", {12'd0, sum, c_out, ovf, res_valid, start_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 3 cycles, start pulses ignored.
    res_ready = 1'b0;
    @(negedge clk);
    start_valid = 1'b1;
    op_a = 16'h00FF;
    op_b = 16'h0001;
    c_in = 1'b0;
    sub  = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp latency", 32'(lat), 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d", k), {13'd0, sum, c_out, res_valid, start_ready},
          {13'd0, 16'h0100, 1'b0, 1'b1, 1'b0});
      start_valid = 1'b1;
      op_a = 16'hAAAA;
      op_b = 16'h1111;
    end
    @(negedge clk);
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release", {30'd0, res_valid, start_ready}, 32'b01);
    repeat (3) @(posedge clk);
    #1;
    chk("bp no phantom op", {14'd0, sum, res_valid, start_ready}, {14'd0, 16'h0100, 1'b0, 1'b1});

    // Asynchronous reset in the middle of ADD discards the operation.
    @(negedge clk);
    start_valid = 1'b1;
    op_a = 16'h3333;
    op_b = 16'h1111;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset", {14'd0, sum, res_valid, start_ready}, {14'd0, 16'h0000, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    v = '{16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0};
    run_op(v, "post reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
